// File: rtl/regfile_xfer.sv
// Sequential save/restore engine for the 32-entry register file: dumps x1..x31
// onto a valid/ready stream, or restores x1..x31 from one.
module regfile_xfer #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic            i_mode,
  input  logic            i_abort,
  output logic            o_busy,
  output logic            o_done,
  output logic [4:0]      o_Rnum,
  input  logic [XLEN-1:0] i_Rd,
  output logic            o_Wen,
  output logic [4:0]      o_Wnum,
  output logic [XLEN-1:0] o_Wd,
  output logic            o_tx_valid,
  output logic [XLEN-1:0] o_tx_data,
  output logic            o_tx_last,
  input  logic            i_tx_ready,
  input  logic            i_rx_valid,
  input  logic [XLEN-1:0] i_rx_data,
  output logic            o_rx_ready
);

  typedef enum logic [1:0] {IDLE, DUMP, LOAD, DRAIN} state_t;

  state_t     state, state_nx;
  logic [4:0] idx;
  logic       pend;
  logic       tx_fire, tx_load, rx_fire;

  assign tx_fire = o_tx_valid && i_tx_ready;
  assign tx_load = (state == DUMP) && !pend && (!o_tx_valid || i_tx_ready);
  assign rx_fire = (state == LOAD) && i_rx_valid && o_rx_ready;
  assign o_busy  = (state != IDLE);
  assign o_Rnum  = (state == DUMP) ? idx : 5'd0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (i_start) state_nx = i_mode ? LOAD : DUMP;
      DUMP: begin
        if (i_abort)                     state_nx = IDLE;
        else if (tx_fire && o_tx_last)   state_nx = IDLE;
      end
      LOAD: begin
        if (i_abort)                     state_nx = IDLE;
        else if (rx_fire && idx == 5'd31) state_nx = DRAIN;
      end
      DRAIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath; abort wins over any handshake in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idx        <= 5'd1;
      pend       <= 1'b0;
      o_done     <= 1'b0;
      o_Wen      <= 1'b0;
      o_Wnum     <= 5'd0;
      o_Wd       <= '0;
      o_tx_valid <= 1'b0;
      o_tx_data  <= '0;
      o_tx_last  <= 1'b0;
      o_rx_ready <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_Wen  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            idx        <= 5'd1;
            pend       <= 1'b0;
            o_rx_ready <= i_mode;
          end
        end
        DUMP: begin
          if (i_abort) begin
            o_tx_valid <= 1'b0;
            o_tx_last  <= 1'b0;
            pend       <= 1'b0;
          end else if (tx_load) begin
            o_tx_data  <= i_Rd;
            o_tx_valid <= 1'b1;
            o_tx_last  <= (idx == 5'd31);
            if (idx == 5'd31) pend <= 1'b1;
            else              idx  <= idx + 5'd1;
          end else if (tx_fire) begin
            // only reachable for the final word, since pend blocks reloading
            o_tx_valid <= 1'b0;
            o_tx_last  <= 1'b0;
            pend       <= 1'b0;
            o_done     <= 1'b1;
          end
        end
        LOAD: begin
          if (i_abort) begin
            o_rx_ready <= 1'b0;
          end else if (rx_fire) begin
            o_Wen  <= 1'b1;
            o_Wnum <= idx;
            o_Wd   <= i_rx_data;
            idx    <= idx + 5'd1;
            if (idx == 5'd31) o_rx_ready <= 1'b0;
          end
        end
        DRAIN: begin
          if (!i_abort) o_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_xfer.sv
// Directed bench for regfile_xfer with a behavioural register file attached.
module tb_regfile_xfer;
  localparam int XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic            i_start = 1'b0, i_mode = 1'b0, i_abort = 1'b0;
  logic            o_busy, o_done;
  logic [4:0]      o_Rnum, o_Wnum;
  logic [XLEN-1:0] i_Rd, o_Wd, o_tx_data;
  logic            o_Wen, o_tx_valid, o_tx_last;
  logic            i_tx_ready = 1'b0;
  logic            i_rx_valid = 1'b0;
  logic [XLEN-1:0] i_rx_data = '0;
  logic            o_rx_ready;

  regfile_xfer #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mode(i_mode),
    .i_abort(i_abort), .o_busy(o_busy), .o_done(o_done), .o_Rnum(o_Rnum),
    .i_Rd(i_Rd), .o_Wen(o_Wen), .o_Wnum(o_Wnum), .o_Wd(o_Wd),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .o_tx_last(o_tx_last),
    .i_tx_ready(i_tx_ready), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_rx_ready(o_rx_ready)
  );

  always #5 i_clk = ~i_clk;

  // register file model: pre_sel 1 loads 0x1000+k, 2 loads 0x55000000+k
  logic [XLEN-1:0] rf [32];
  int pre_sel = 0;
  always @(posedge i_clk) begin
    if (pre_sel == 1) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : 32'h1000 + i;
    end else if (pre_sel == 2) begin
      for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : 32'h5500_0000 + i;
    end else if (o_Wen && o_Wnum != 5'd0) begin
      rf[o_Wnum] <= o_Wd;
    end
  end
  assign i_Rd = rf[o_Rnum];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int sel);
    @(negedge i_clk) pre_sel = sel;
    @(negedge i_clk) pre_sel = 0;
  endtask

  logic [XLEN-1:0] got [$];
  logic [XLEN-1:0] held;
  logic            held_last, stalled, rdy, v, done_seen, found;
  int              acc, wen_cnt;

  initial begin
    // reset state
    #1;
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_tx_last", o_tx_last, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_rx_ready", o_rx_ready, 0);
    check("rst_wen", o_Wen, 0);
    check("rst_wnum", o_Wnum, 0);
    check("rst_wd", o_Wd, 0);
    check("rst_rnum", o_Rnum, 0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;

    // dump with ready held high
    preload(1);
    i_tx_ready = 1'b1; i_mode = 1'b0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check("d1_busy_e0", o_busy, 1);
    check("d1_valid_e0", o_tx_valid, 0);
    check("d1_rnum_e0", o_Rnum, 1);
    for (int k = 1; k <= 31; k++) begin
      @(negedge i_clk);
      check($sformatf("d1_valid_%0d", k), o_tx_valid, 1);
      check($sformatf("d1_data_%0d", k), o_tx_data, 32'h1000 + k);
      check($sformatf("d1_last_%0d", k), o_tx_last, (k == 31));
    end
    @(negedge i_clk);
    check("d1_done", o_done, 1);
    check("d1_busy_end", o_busy, 0);
    check("d1_valid_end", o_tx_valid, 0);
    @(negedge i_clk);
    check("d1_done_once", o_done, 0);

    // dump with ready toggling 1,0,1,0
    got.delete(); stalled = 0; done_seen = 0; held = '0; held_last = 0;
    i_start = 1'b1; i_mode = 1'b0;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (stalled) begin
        check("d2_hold_data", o_tx_data, held);
        check("d2_hold_last", o_tx_last, held_last);
      end
      if (o_done) begin done_seen = 1; break; end
      rdy = (cyc % 2 == 0);
      i_tx_ready = rdy;
      if (o_tx_valid && rdy) got.push_back(o_tx_data);
      stalled = o_tx_valid && !rdy;
      held = o_tx_data; held_last = o_tx_last;
      @(negedge i_clk);
    end
    check("d2_done", done_seen, 1);
    check("d2_count", got.size(), 31);
    for (int k = 0; k < got.size() && k < 31; k++)
      check($sformatf("d2_word_%0d", k + 1), got[k], 32'h1000 + k + 1);
    i_tx_ready = 1'b0;

    // restore, valid low every third cycle, then a 32nd word offered late
    preload(2);
    acc = 0; wen_cnt = 0; done_seen = 0;
    i_start = 1'b1; i_mode = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    check("r_ready_e0", o_rx_ready, 1);
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (o_Wen) wen_cnt++;
      if (o_done) begin done_seen = 1; break; end
      v = (cyc % 3 != 2) && (acc < 31);
      i_rx_valid = v;
      i_rx_data = 32'hA000_0000 + acc + 1;
      if (v && o_rx_ready) acc++;
      @(negedge i_clk);
    end
    check("r_done", done_seen, 1);
    check("r_busy_end", o_busy, 0);
    check("r_accepted", acc, 31);
    i_rx_valid = 1'b1; i_rx_data = 32'hDEAD_BEEF;
    repeat (2) begin
      check("r_late_ready", o_rx_ready, 0);
      if (o_Wen) wen_cnt++;
      @(negedge i_clk);
    end
    i_rx_valid = 1'b0;
    check("r_wen_pulses", wen_cnt, 31);
    check("r_x0", rf[0], 0);
    for (int k = 1; k <= 31; k++)
      check($sformatf("r_x%0d", k), rf[k], 32'hA000_0000 + k);

    // abort in dump after 10 handshakes
    preload(1);
    i_tx_ready = 1'b1; i_mode = 1'b0; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge i_clk);
      if (o_tx_valid && o_tx_data == 32'h100B) begin found = 1; break; end
    end
    check("a_reach_x11", found, 1);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    check("a_busy", o_busy, 0);
    check("a_valid", o_tx_valid, 0);
    check("a_last", o_tx_last, 0);
    check("a_done", o_done, 0);
    @(negedge i_clk);
    check("a_done_later", o_done, 0);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    @(negedge i_clk);
    check("a_restart_valid", o_tx_valid, 1);
    check("a_restart_data", o_tx_data, 32'h1001);
    check("a_restart_rnum", o_Rnum, 2);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    check("a2_busy", o_busy, 0);

    // async reset during restore at word 5
    preload(2);
    i_tx_ready = 1'b0; acc = 0;
    i_start = 1'b1; i_mode = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    for (int cyc = 0; cyc < 20 && acc < 5; cyc++) begin
      i_rx_valid = 1'b1;
      i_rx_data = 32'hB000_0000 + acc + 1;
      if (o_rx_ready) acc++;
      @(negedge i_clk);
    end
    check("ar_accepted", acc, 5);
    check("ar_wen_before", o_Wen, 1);
    #1 i_rst_n = 1'b0;
    #1;
    check("ar_wen", o_Wen, 0);
    check("ar_rx_ready", o_rx_ready, 0);
    check("ar_busy", o_busy, 0);
    i_rx_valid = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("ar_idle_busy", o_busy, 0);
    check("ar_idle_done", o_done, 0);
    for (int k = 1; k <= 4; k++)
      check($sformatf("ar_x%0d", k), rf[k], 32'hB000_0000 + k);
    check("ar_x6", rf[6], 32'h5500_0006);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_xfer.md
# regfile_xfer

Sequential save/restore engine for the 32-entry integer register file. In dump mode it walks x1..x31 through one read port and streams each value out over a valid/ready channel. In restore mode it accepts a valid/ready stream and writes it back to x1..x31 through the write port. It sits between the register file and the debug/context-switch logic; the top level muxes its read and write port signals onto the register file while `o_busy` is high, and the core is stalled for that time.

## Interface
- `XLEN`, 32: data width; must match the register file word width.
- `i_clk`  in  1  clock; all state changes on rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  start request; sampled only in IDLE.
- `i_mode`  in  1  sampled with `i_start`: 0 = dump, 1 = restore.
- `i_abort`  in  1  cancel the current operation.
- `o_busy`  out  1  high while not in IDLE.
- `o_done`  out  1  one-cycle pulse when an operation completes normally.
- `o_Rnum`  out  5  register file read address.
- `i_Rd`  in  XLEN  register file read data (combinational).
- `o_Wen`  out  1  register file write enable.
- `o_Wnum`  out  5  register file write address.
- `o_Wd`  out  XLEN  register file write data.
- `o_tx_valid`, `o_tx_data[XLEN]`, `o_tx_last`  out  dump stream.
- `i_tx_ready`  in  1  dump stream back-pressure.
- `i_rx_valid`, `i_rx_data[XLEN]`  in  restore stream.
- `o_rx_ready`  out  1  restore stream back-pressure.

## Operation
- States: IDLE, DUMP, LOAD, DRAIN. Internal 5-bit index `idx`, plus a `pend` flag in DUMP that is set once x31 has been loaded into the output register.
- Reset (async): state = IDLE, `idx` = 1, and every output register is 0. That means `o_busy`, `o_done`, `o_Wen`, `o_Wnum`, `o_Wd`, `o_tx_valid`, `o_tx_data`, `o_tx_last`, `o_rx_ready` and `o_Rnum` are all 0.
- IDLE, on `i_start`=1: go to DUMP if `i_mode`=0, or to LOAD if `i_mode`=1. Set `idx` = 1.
- `i_start` is ignored outside IDLE.
- `o_Rnum` = `idx` in DUMP and 0 otherwise. It is combinational from the state/`idx` registers.
- DUMP load condition: `!pend && (!o_tx_valid || i_tx_ready)`. When it holds, the block loads `o_tx_data` <= `i_Rd`, sets `o_tx_valid` <= 1 and `o_tx_last` <= (`idx`==31).
  - If `idx`==31, set `pend`; otherwise `idx` increments.
- DUMP hold rule: while `o_tx_valid && !i_tx_ready`, `o_tx_data` and `o_tx_last` hold.
- DUMP exit: the handshake with `o_tx_last`=1 clears `o_tx_valid` and moves to IDLE. `o_done` = 1 for the next cycle.
- LOAD: `o_rx_ready` = 1 (registered, set on entry). On each `i_rx_valid && o_rx_ready`, the block registers `o_Wen` <= 1, `o_Wnum` <= `idx` and `o_Wd` <= `i_rx_data`, then increments `idx`.
  - No handshake: `o_Wen` <= 0.
- LOAD exit: the handshake at `idx`==31 clears `o_rx_ready` and moves to DRAIN.
- DRAIN: `o_Wen` = 1 for x31 in this cycle. Next edge: `o_Wen` <= 0, go to IDLE, `o_done` = 1 for one cycle.
- x0 is never read, streamed or written. A dump always produces exactly 31 words; a restore always consumes exactly 31 words.
- `i_abort` in DUMP/LOAD/DRAIN: next edge goes to IDLE and clears `o_tx_valid`, `o_tx_last`, `o_rx_ready`, `o_Wen` and `pend`. No `o_done` is issued. A write already registered before the abort edge completes on that edge; no further writes occur.
- `i_abort` has priority over handshakes in the same cycle.
- Coherency: a snapshot is consistent only if no other register file writes occur while `o_busy`=1. The top level guarantees this.

## Timing
- `i_start` sampled at edge E0. `o_busy` = 1 from E0.
- Dump, `i_tx_ready` held at 1: x(k) is valid after edge Ek, for k=1..31, one word per cycle.
  - `o_tx_last` is set with x31 after E31.
  - Handshake at E32. `o_done` = 1 and `o_busy` = 0 in the cycle after E32.
- Dump back-pressure: each cycle with `i_tx_ready`=0 while valid delays all later words by one cycle. There are no bubbles otherwise.
- Restore: `o_rx_ready` = 1 after E0. A handshake at edge Eh writes the register file at Eh+1.
  - Last handshake at Eh31 gives DRAIN after Eh31, the x31 write at Eh31+1, and `o_done` in the cycle after that.
- `o_done` and `o_busy` are mutually exclusive. `o_done` is never wider than one cycle.
- Reset asserted mid-operation: all outputs go to 0 immediately (asynchronously). After release the block is in IDLE.

## Test plan
- Dump, ready=1, regfile preloaded with x(k)=0x1000+k:
  - Stream is 0x1001..0x101F on 31 consecutive cycles.
  - `o_tx_last` is high only on 0x101F.
  - `o_done` is high the cycle after the last handshake; total 33 cycles from E0.
- Dump with `i_tx_ready` toggling 1,0,1,0:
  - Data is held stable while stalled.
  - Same 31 values arrive in order; no duplicates or drops.
- Restore of 0xA0000000+k with `i_rx_valid` low every third cycle:
  - Regfile x1..x31 = 0xA0000001..0xA000001F.
  - x0 is still read as 0.
  - Exactly 31 `o_Wen` pulses.
- Restore whose 32nd word is offered after `o_done`:
  - Word is not accepted (`o_rx_ready`=0).
  - x31 is unchanged by it.
- Abort in DUMP after 10 handshakes:
  - IDLE on the next edge; `o_tx_valid`=0; no `o_done`.
  - A new dump then starts at x1.
- Async reset asserted during LOAD at word 5:
  - `o_Wen`, `o_rx_ready` and `o_busy` drop to 0 immediately.
  - x1..x4 are written; x5 is written only if its handshake preceded the reset.
